cabac_bin_ctrl: RTL and testbench
=================================

Name: cabac_bin_ctrl

Overview:
- Sequencer for the regular-bin arithmetic decode datapath (DecodeBin).
- Owns the arithmetic-decoder state registers (range, value) and a left-aligned bitstream bit buffer fed by a byte handshake.
- Accepts one bin request at a time, drives the combinational datapath from its registers, and commits the datapath result.
- On every commit it refills the vacated low value bits with fresh stream bits, stalling when the buffer is short.
- Datapath ports are external, so the bench can substitute a stub.

Parameters:
- BIN_WIDTH, 4, width of datapath bin output; only bit 0 is used.
- INIT_RANGE, 510, range loaded at initialisation.
- BUF_W, 16, bit-buffer width; fixed at 16.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: (re)initialise decoder from stream; aborts any operation in flight
- bs_valid  in  1  stream byte valid
- bs_data  in  8  stream byte, MSB first
- bs_ready  out  1  byte accepted when bs_valid&bs_ready
- req_valid  in  1  bin request valid
- req_state  in  8  probability state for the request
- req_ready  out  1  controller can accept a request
- bin_valid  out  1  one-cycle pulse, result valid
- bin  out  1  decoded bin
- bin_lps  out  1  1 = LPS path taken (for context update)
- dp_range  out  9  to datapath m_range_in (= range register)
- dp_value  out  16  to datapath m_value_in (= value register)
- dp_state  out  8  to datapath pState_in (= latched request state)
- dp_bin  in  BIN_WIDTH  datapath bin_out
- dp_lps  in  1  datapath lps
- dp_mps_renorm  in  1  datapath mps_renorm (active-low: 0 = MPS renorm)
- dp_numbits  in  3  datapath numBits_out
- dp_range_out  in  9  datapath m_range_out
- dp_value_out  in  16  datapath m_value_out (low bits zero-filled)

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; range=0; value=0; buf=0; cnt=0; state_q=0; bs_ready=0; req_ready=0; bin_valid=0; bin=0; bin_lps=0.
- Shift amount: shift = dp_lps ? dp_numbits : (dp_mps_renorm ? 0 : 1). dp_numbits is ignored on a non-renorm MPS.
- Bit buffer: valid bits are left-aligned in buf[15:16-cnt], with cnt in 0..16.
- bs_ready = (state != IDLE) && (cnt <= 8).
- Byte accept: buf[15-cnt -: 8] <= bs_data, cnt += 8.
- Bit take of n bits: fresh = buf >> (16-n), buf <<= n, cnt -= n.
- Same-cycle accept and take: the take is applied first, the byte is inserted at the post-take cnt, and bs_ready is evaluated on the pre-take cnt.
- FSM IDLE: req_ready=0, bs_ready=0. start -> INIT.
- FSM INIT: buf and cnt are cleared on entry, then bytes are accepted.
  - When cnt==16: value<=buf, buf<=0, cnt<=0, range<=INIT_RANGE, go to READY.
  - In the cycle the second byte is accepted, cnt becomes 16, so READY is entered on the following edge.
- FSM READY: req_ready=1. On req_valid: state_q<=req_state, go to EVAL.
- FSM EVAL: datapath is evaluated combinationally from range, value and state_q.
  - If cnt >= shift, commit: range<=dp_range_out, value<=dp_value_out | fresh(shift), take shift bits, bin<=dp_bin[0], bin_lps<=dp_lps, bin_valid<=1 next cycle, go to READY.
  - Otherwise go to WAIT_BITS.
- FSM WAIT_BITS: the datapath inputs are held, so its outputs stay stable. Commit, exactly as in EVAL, on the first cycle with cnt >= shift.
- Latency: request accepted at edge N → EVAL in cycle N+1 → bin_valid high in cycle N+2 when no stall. req_ready is low in EVAL and WAIT_BITS. Maximum throughput is 1 bin per 2 cycles.
- bin_valid is high for exactly one cycle. bin and bin_lps hold their value until the next commit.
- A bin is never committed with missing bits; shift==0 never stalls.
- start in any state: go to INIT and clear buf and cnt.
  - Any pending request is dropped without a bin_valid.
  - A byte presented in the start cycle is not accepted.
- rst overrides start.
- Width rule: range and value are taken from the datapath as-is; the controller does no arithmetic on them except the OR-in of fresh bits.

Test Plan:
- Init: start, then bytes 0x12, 0x34 → value=0x1234, range=510, READY two edges after the second byte, req_ready=1.
- MPS without renorm (stub: dp_lps=0, dp_mps_renorm=1, range_out=400, value_out=0x1234, bin=1) → bin_valid 2 cycles after accept, bin=1, range=400, value=0x1234, cnt unchanged.
- MPS with renorm (stub: mps_renorm=0, range_out=0x1F0, value_out=0x2468, buffer holding 0xAB) → value=0x2469, cnt 8→7, buf=0x5600.
- LPS with 6-bit shift and cnt=3 → WAIT_BITS, no bin_valid. Then byte 0xFF → commit one cycle later, fresh bits OR'd correctly, cnt=5.
- start asserted in WAIT_BITS → no bin_valid, INIT, cnt=0; re-init with 0x00, 0x01 → value=0x0001.
- rst asserted mid-EVAL → all outputs at reset values next cycle, IDLE, bs_ready=0.

Source files
------------

// File: rtl/cabac_bin_ctrl.sv
// rtl/cabac_bin_ctrl.sv - regular-bin decode sequencer: range/value registers, bit buffer, datapath commit
module cabac_bin_ctrl #(
  parameter int         BIN_WIDTH  = 4,
  parameter logic [8:0] INIT_RANGE = 9'd510,
  parameter int         BUF_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bs_valid,
  input  logic [7:0]           bs_data,
  output logic                 bs_ready,
  input  logic                 req_valid,
  input  logic [7:0]           req_state,
  output logic                 req_ready,
  output logic                 bin_valid,
  output logic                 bin,
  output logic                 bin_lps,
  output logic [8:0]           dp_range,
  output logic [15:0]          dp_value,
  output logic [7:0]           dp_state,
  input  logic [BIN_WIDTH-1:0] dp_bin,
  input  logic                 dp_lps,
  input  logic                 dp_mps_renorm,
  input  logic [2:0]           dp_numbits,
  input  logic [8:0]           dp_range_out,
  input  logic [15:0]          dp_value_out
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INIT      = 3'd1;
  localparam logic [2:0] READY     = 3'd2;
  localparam logic [2:0] EVAL      = 3'd3;
  localparam logic [2:0] WAIT_BITS = 3'd4;

  localparam logic [4:0] BUF_BITS = 5'(BUF_W);

  logic [2:0]       fsm_q;
  logic [8:0]       range_q;
  logic [15:0]      value_q;
  logic [BUF_W-1:0] bit_buf_q;
  logic [4:0]       cnt_q;
  logic [7:0]       state_q;
  logic             bin_valid_q;
  logic             bin_q;
  logic             bin_lps_q;

  logic [2:0]       shift;
  logic             commit;
  logic [2:0]       take_n;
  logic [BUF_W-1:0] fresh;
  logic [BUF_W-1:0] buf_taken;
  logic [4:0]       cnt_taken;
  logic             accept;
  logic [BUF_W-1:0] buf_next;
  logic [4:0]       cnt_next;

  // only bit 0 of the datapath bin carries information
  logic unused_dp_bin;
  assign unused_dp_bin = ^dp_bin;

  assign bs_ready  = (fsm_q != IDLE) && (cnt_q <= 5'd8);
  assign req_ready = (fsm_q == READY);
  assign bin_valid = bin_valid_q;
  assign bin       = bin_q;
  assign bin_lps   = bin_lps_q;
  assign dp_range  = range_q;
  assign dp_value  = value_q;
  assign dp_state  = state_q;

  // take is applied before the byte insert, so the byte lands at the post-take count
  always_comb begin
    shift     = dp_lps ? dp_numbits : (dp_mps_renorm ? 3'd0 : 3'd1);
    commit    = ((fsm_q == EVAL) || (fsm_q == WAIT_BITS)) && ({2'b00, shift} <= cnt_q) && !start;
    take_n    = commit ? shift : 3'd0;
    fresh     = bit_buf_q >> (BUF_BITS - {2'b00, take_n});
    buf_taken = bit_buf_q << take_n;
    cnt_taken = cnt_q - {2'b00, take_n};
    accept    = bs_valid && bs_ready && !start;
    buf_next  = buf_taken;
    cnt_next  = cnt_taken;
    if (accept) begin
      buf_next = (buf_taken & ~(16'hFF00 >> cnt_taken)) | ({bs_data, 8'h00} >> cnt_taken);
      cnt_next = cnt_taken + 5'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      range_q     <= '0;
      value_q     <= '0;
      bit_buf_q   <= '0;
      cnt_q       <= '0;
      state_q     <= '0;
      bin_valid_q <= 1'b0;
      bin_q       <= 1'b0;
      bin_lps_q   <= 1'b0;
    end else begin
      bin_valid_q <= 1'b0;
      if (start) begin
        fsm_q     <= INIT;
        bit_buf_q <= '0;
        cnt_q     <= '0;
      end else begin
        bit_buf_q <= buf_next;
        cnt_q     <= cnt_next;
        case (fsm_q)
          IDLE: ;
          INIT: begin
            if (cnt_q == 5'd16) begin
              value_q   <= bit_buf_q;
              range_q   <= INIT_RANGE;
              bit_buf_q <= '0;
              cnt_q     <= '0;
              fsm_q     <= READY;
            end
          end
          READY: begin
            if (req_valid) begin
              state_q <= req_state;
              fsm_q   <= EVAL;
            end
          end
          EVAL, WAIT_BITS: begin
            if (commit) begin
              range_q     <= dp_range_out;
              value_q     <= dp_value_out | fresh;
              bin_q       <= dp_bin[0];
              bin_lps_q   <= dp_lps;
              bin_valid_q <= 1'b1;
              fsm_q       <= READY;
            end else begin
              fsm_q <= WAIT_BITS;
            end
          end
          default: fsm_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cabac_bin_ctrl.sv
// tb/tb_cabac_bin_ctrl.sv - scoreboard bench for cabac_bin_ctrl with a stubbed datapath
module tb_cabac_bin_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        bs_valid;
  logic [7:0]  bs_data;
  logic        bs_ready;
  logic        req_valid;
  logic [7:0]  req_state;
  logic        req_ready;
  logic        bin_valid;
  logic        bin;
  logic        bin_lps;
  logic [8:0]  dp_range;
  logic [15:0] dp_value;
  logic [7:0]  dp_state;
  logic [3:0]  dp_bin;
  logic        dp_lps;
  logic        dp_mps_renorm;
  logic [2:0]  dp_numbits;
  logic [8:0]  dp_range_out;
  logic [15:0] dp_value_out;

  cabac_bin_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
    .req_valid(req_valid), .req_state(req_state), .req_ready(req_ready),
    .bin_valid(bin_valid), .bin(bin), .bin_lps(bin_lps),
    .dp_range(dp_range), .dp_value(dp_value), .dp_state(dp_state),
    .dp_bin(dp_bin), .dp_lps(dp_lps), .dp_mps_renorm(dp_mps_renorm),
    .dp_numbits(dp_numbits), .dp_range_out(dp_range_out), .dp_value_out(dp_value_out)
  );

  typedef struct packed {
    logic        b;
    logic        l;
    logic [8:0]  r;
    logic [15:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bin_valid) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_bin_valid: got 1 expected 0");
      end else begin
        e = exp_q.pop_front();
        chk("sb_bin", int'(bin), int'(e.b));
        chk("sb_bin_lps", int'(bin_lps), int'(e.l));
        chk("sb_range", int'(dp_range), int'(e.r));
        chk("sb_value", int'(dp_value), int'(e.v));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    bs_valid = 1'b1;
    bs_data  = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bs_ready;
      step();
    end
    bs_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic issue_req(input logic [7:0] s);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1;
    req_state = s;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      step();
    end
    req_valid = 1'b0;
    if (!acc) chk("req_accept_timeout", 0, 1);
  endtask

  task automatic stub(input logic lps, input logic mr, input logic [2:0] nb,
                      input logic [8:0] r, input logic [15:0] v, input logic [3:0] b);
    dp_lps        = lps;
    dp_mps_renorm = mr;
    dp_numbits    = nb;
    dp_range_out  = r;
    dp_value_out  = v;
    dp_bin        = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
    req_valid = 1'b0; req_state = '0;
    stub(1'b0, 1'b1, 3'd0, 9'd0, 16'h0, 4'h0);
    step(); step();
    chk("rst_bs_ready", int'(bs_ready), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_bin_valid", int'(bin_valid), 0);
    chk("rst_range", int'(dp_range), 0);
    chk("rst_value", int'(dp_value), 0);
    rst = 1'b0;
    step();
    chk("idle_bs_ready", int'(bs_ready), 0);

    // init from 0x12 0x34
    start = 1'b1; step(); start = 1'b0;
    chk("init_bs_ready", int'(bs_ready), 1);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("init_not_ready_yet", int'(req_ready), 0);
    step();
    chk("init_req_ready", int'(req_ready), 1);
    chk("init_value", int'(dp_value), 16'h1234);
    chk("init_range", int'(dp_range), 510);

    // MPS without renorm, dp_bin upper bits set to show only bit 0 matters
    stub(1'b0, 1'b1, 3'd7, 9'd400, 16'h1234, 4'b0011);
    exp_q.push_back('{1'b1, 1'b0, 9'd400, 16'h1234});
    issue_req(8'h2A);
    chk("eval_dp_state", int'(dp_state), 8'h2A);
    chk("eval_req_ready", int'(req_ready), 0);
    chk("eval_no_bin_yet", int'(bin_valid), 0);
    step();
    chk("mps_latency", int'(bin_valid), 1);
    chk("mps_cnt", int'(dut.cnt_q), 0);
    step();
    chk("bin_valid_one_cycle", int'(bin_valid), 0);
    chk("bin_held", int'(bin), 1);

    // MPS with renorm over buffered 0xAB
    send_byte(8'hAB);
    stub(1'b0, 1'b0, 3'd5, 9'h1F0, 16'h2468, 4'b1110);
    exp_q.push_back('{1'b0, 1'b0, 9'h1F0, 16'h2469});
    issue_req(8'h11);
    step();
    chk("renorm_bin_valid", int'(bin_valid), 1);
    chk("renorm_cnt", int'(dut.cnt_q), 7);
    chk("renorm_buf", int'(dut.bit_buf_q), 16'h5600);

    // LPS shift 4: fresh 0x5, leaves cnt 3, buf 0x6000
    stub(1'b1, 1'b1, 3'd4, 9'h100, 16'h3450, 4'b0001);
    exp_q.push_back('{1'b1, 1'b1, 9'h100, 16'h3455});
    issue_req(8'h05);
    step();
    chk("lps4_cnt", int'(dut.cnt_q), 3);
    chk("lps4_buf", int'(dut.bit_buf_q), 16'h6000);

    // LPS shift 6 with only 3 bits: stalls until 0xFF arrives
    stub(1'b1, 1'b0, 3'd6, 9'h0C0, 16'h4A40, 4'b0000);
    exp_q.push_back('{1'b0, 1'b1, 9'h0C0, 16'h4A5F});
    issue_req(8'h22);
    step(); step();
    chk("stall_no_bin", int'(bin_valid), 0);
    chk("stall_req_ready", int'(req_ready), 0);
    send_byte(8'hFF);
    chk("stall_after_byte", int'(bin_valid), 0);
    step();
    chk("stall_commit", int'(bin_valid), 1);
    chk("stall_cnt", int'(dut.cnt_q), 5);
    chk("stall_buf", int'(dut.bit_buf_q), 16'hF800);

    // start while stalled in WAIT_BITS drops the request
    stub(1'b1, 1'b0, 3'd7, 9'h111, 16'h0, 4'b0001);
    issue_req(8'h33);
    step(); step();
    chk("wait_no_bin", int'(bin_valid), 0);
    start = 1'b1; bs_valid = 1'b1; bs_data = 8'h55;
    step();
    start = 1'b0; bs_valid = 1'b0;
    chk("start_cnt", int'(dut.cnt_q), 0);
    chk("start_no_bin", int'(bin_valid), 0);
    chk("start_req_ready", int'(req_ready), 0);
    send_byte(8'h00);
    send_byte(8'h01);
    step();
    chk("reinit_value", int'(dp_value), 16'h0001);
    chk("reinit_range", int'(dp_range), 510);
    chk("reinit_req_ready", int'(req_ready), 1);

    // rst in EVAL
    stub(1'b0, 1'b1, 3'd0, 9'h155, 16'h7777, 4'b0001);
    issue_req(8'h44);
    rst = 1'b1;
    step();
    chk("rst_eval_bin_valid", int'(bin_valid), 0);
    chk("rst_eval_bin_lps", int'(bin_lps), 0);
    chk("rst_eval_range", int'(dp_range), 0);
    chk("rst_eval_value", int'(dp_value), 0);
    chk("rst_eval_state", int'(dp_state), 0);
    chk("rst_eval_bs_ready", int'(bs_ready), 0);
    chk("rst_eval_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    step(); step(); step();
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
